// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: prefix bytes, ignore list, decoder states, event record.
package ps2_pkg;

    localparam logic [7:0] PS2_E0 = 8'hE0;   // extended-key prefix
    localparam logic [7:0] PS2_F0 = 8'hF0;   // break (release) prefix
    localparam int         EV_W   = 10;      // width of ps2_event_t

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_t;

    typedef struct packed {
        logic       ext;
        logic       make;
        logic [7:0] code;
    } ps2_event_t;

    // Controller/keyboard housekeeping bytes that never describe a key.
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hFA) ||
               (b == 8'hFE) || (b == 8'hEE) || (b == 8'hFF);
    endfunction

    // Two-digit BCD increment, 99 wraps to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = v[7:4];
        lo = v[3:0];
        if (lo == 4'd9) begin
            lo = 4'd0;
            hi = (hi == 4'd9) ? 4'd0 : hi + 4'd1;
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event queue; head is visible the cycle after the write.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int REC_W      = 10
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [REC_W-1:0] din,
    input  logic             pop,
    output logic [REC_W-1:0] dout,
    output logic             valid,
    output logic             full,
    output logic             drop
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [REC_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_pop;
    logic             do_push;

    assign valid   = (count != '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign do_pop  = pop && valid;
    // A pop in the same cycle frees the slot, so a full queue still takes the push.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    // Empty queue presents an all-zero record so outputs match reset values.
    assign dout    = valid ? mem[rd_ptr] : '0;

    // Pointer and occupancy update; power-of-two depth makes pointers wrap naturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage write; contents are don't-care until the slot is counted valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ps2_key_event.sv
// PS/2 scancode decoder: prefix FSM, typematic filter, held-key tracker, BCD press counter.
module ps2_key_event
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] code_in,
    input  logic       code_valid,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_make,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic       held,
    output logic [8:0] held_code,
    output logic [7:0] press_cnt,
    output logic       overflow
);

    ps2_state_t state, state_nxt;
    ps2_event_t dec_rec;
    ps2_event_t head_rec;
    logic       dec_valid;
    logic       key_match;
    logic       ev_push;
    logic       ev_pop;
    logic       q_full;
    logic       q_drop;

    // Decoder state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Prefix tracking; housekeeping bytes abort any partial sequence.
    always_comb begin
        state_nxt = state;
        if (code_valid) begin
            if (is_ignored(code_in)) begin
                state_nxt = ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE:    state_nxt = (code_in == PS2_E0) ? ST_EXT :
                                            (code_in == PS2_F0) ? ST_BRK : ST_IDLE;
                    ST_EXT:     state_nxt = (code_in == PS2_F0) ? ST_EXT_BRK :
                                            (code_in == PS2_E0) ? ST_EXT : ST_IDLE;
                    ST_BRK:     state_nxt = (code_in == PS2_F0 || code_in == PS2_E0) ?
                                            ST_BRK : ST_IDLE;
                    ST_EXT_BRK: state_nxt = (code_in == PS2_F0 || code_in == PS2_E0) ?
                                            ST_EXT_BRK : ST_IDLE;
                    default:    state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    // Event decode: a non-prefix, non-ignored byte completes a make or break.
    always_comb begin
        dec_valid    = 1'b0;
        dec_rec      = '0;
        dec_rec.code = code_in;
        dec_rec.ext  = (state == ST_EXT) || (state == ST_EXT_BRK);
        dec_rec.make = (state == ST_IDLE) || (state == ST_EXT);
        if (code_valid && !is_ignored(code_in) &&
            code_in != PS2_E0 && code_in != PS2_F0) begin
            dec_valid = 1'b1;
        end
    end

    assign key_match = held && ({dec_rec.ext, dec_rec.code} == held_code);
    // Typematic repeats of the held key are swallowed; breaks always go out.
    assign ev_push   = dec_valid && !(dec_rec.make && key_match);
    assign ev_pop    = ev_valid && ev_ready;

    // Held key and press counter track accepted events even when the queue drops them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            held      <= 1'b0;
            held_code <= '0;
            press_cnt <= '0;
        end else if (dec_valid) begin
            if (dec_rec.make && !key_match) begin
                held      <= 1'b1;
                held_code <= {dec_rec.ext, dec_rec.code};
                press_cnt <= bcd_inc(press_cnt);
            end else if (!dec_rec.make && key_match) begin
                held      <= 1'b0;
            end
        end
    end

    // Sticky overflow flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     overflow <= 1'b0;
        else if (q_drop) overflow <= 1'b1;
    end

    ps2_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .REC_W      (EV_W)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (ev_push),
        .din    (dec_rec),
        .pop    (ev_pop),
        .dout   (head_rec),
        .valid  (ev_valid),
        .full   (q_full),
        .drop   (q_drop)
    );

    assign ev_code = head_rec.code;
    assign ev_ext  = head_rec.ext;
    assign ev_make = head_rec.make;

endmodule
